// File: rtl/scn_spi_streamer.sv
// Streams the LCD config bytes and one 504-byte screen from the screen RAM onto the PCD8544 SPI pins, MSB first.
// Optional: define SCN_CFG_EVERY_FRAME_EN to resend the config bytes on every frame instead of only after reset.
module scn_spi_streamer #(
  parameter int ADDR_SIZE = 13,
  parameter int CFG_BYTES = 5,
  parameter int SCN_BYTES = 504,
  parameter int SCN_SEL_W = 4,
  parameter int CLK_DIV   = 4
) (
  input  logic                 sck,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SCN_SEL_W-1:0] scn_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_read,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [7:0]           mem_data,
  output logic                 lcd_sce,
  output logic                 lcd_dc,
  output logic                 lcd_sdin,
  output logic                 lcd_sclk
);

  localparam int IDX_MAX = (SCN_BYTES > CFG_BYTES) ? SCN_BYTES : CFG_BYTES;
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IDX_W-1:0] CFG_LAST = IDX_W'(CFG_BYTES - 1);
  localparam logic [IDX_W-1:0] SCN_LAST = IDX_W'(SCN_BYTES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t                 state_r, state_s;
  logic                   phase_data_r, phase_data_s;
  logic [ADDR_SIZE-1:0]   base_r, base_s;
  logic [IDX_W-1:0]       idx_r, idx_s;
  logic [2:0]             bit_r, bit_s;
  logic [DIV_W-1:0]       div_r, div_s;
  logic [7:0]             shreg_r, shreg_s;
  logic                   busy_r, busy_s;
  logic                   done_r, done_s;
  logic                   mem_read_r, mem_read_s;
  logic [ADDR_SIZE-1:0]   mem_addr_r, mem_addr_s;
  logic                   sce_r, sce_s;
  logic                   dc_r, dc_s;
  logic                   sdin_r, sdin_s;
  logic                   sclk_r, sclk_s;
  logic                   start_phase_s;
`ifndef SCN_CFG_EVERY_FRAME_EN
  logic                   cfg_sent_r, cfg_sent_s;
`endif

  // Screen start address; 504 = 512 - 8 keeps the multiply to two shifts.
  function automatic logic [ADDR_SIZE-1:0] screen_base(input logic [SCN_SEL_W-1:0] sel);
    logic [ADDR_SIZE-1:0] sel_w;
    sel_w = ADDR_SIZE'(sel);
    if (SCN_BYTES == 504) begin
      screen_base = ADDR_SIZE'(CFG_BYTES) + (sel_w << 32'd9) - (sel_w << 32'd3);
    end else begin
      screen_base = ADDR_SIZE'(CFG_BYTES) + sel_w * ADDR_SIZE'(SCN_BYTES);
    end
  endfunction

  // Next-state and next-output logic for the fetch/shift sequencer.
  always_comb begin
    state_s      = state_r;
    phase_data_s = phase_data_r;
    base_s       = base_r;
    idx_s        = idx_r;
    bit_s        = bit_r;
    div_s        = div_r;
    shreg_s      = shreg_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_addr_s   = mem_addr_r;
    sce_s        = sce_r;
    dc_s         = dc_r;
    sdin_s       = sdin_r;
    sclk_s       = sclk_r;
`ifdef SCN_CFG_EVERY_FRAME_EN
    start_phase_s = 1'b0;
`else
    cfg_sent_s    = cfg_sent_r;
    start_phase_s = cfg_sent_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          base_s       = screen_base(scn_sel);
          idx_s        = {IDX_W{1'b0}};
          phase_data_s = start_phase_s;
          busy_s       = 1'b1;
          state_s      = ST_FETCH;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_FETCH: begin
        state_s = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_s = mem_data;
        sdin_s  = mem_data[7];
        dc_s    = phase_data_r;
        sce_s   = 1'b0;
        sclk_s  = 1'b0;
        bit_s   = 3'd0;
        div_s   = {DIV_W{1'b0}};
        state_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_s = {DIV_W{1'b0}};
          if (!sclk_r) begin
            sclk_s = 1'b1;
          end else begin
            sclk_s = 1'b0;
            if (bit_r == 3'd7) begin
              // End of byte: choose the next byte or finish the frame.
              if (!phase_data_r) begin
                if (idx_r == CFG_LAST) begin
                  phase_data_s = 1'b1;
                  idx_s        = {IDX_W{1'b0}};
`ifndef SCN_CFG_EVERY_FRAME_EN
                  cfg_sent_s   = 1'b1;
`endif
                end else begin
                  idx_s = idx_r + IDX_W'(1);
                end
                state_s = ST_FETCH;
              end else begin
                if (idx_r == SCN_LAST) begin
                  done_s  = 1'b1;
                  sce_s   = 1'b1;
                  state_s = ST_FIN;
                end else begin
                  idx_s   = idx_r + IDX_W'(1);
                  state_s = ST_FETCH;
                end
              end
            end else begin
              bit_s   = bit_r + 3'd1;
              sdin_s  = shreg_r[6];
              shreg_s = {shreg_r[6:0], 1'b0};
            end
          end
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      ST_FIN: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        sce_s   = 1'b1;
        sclk_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
    if (state_s == ST_FETCH) begin
      mem_read_s = 1'b1;
      mem_addr_s = phase_data_s ? (base_s + ADDR_SIZE'(idx_s)) : ADDR_SIZE'(idx_s);
    end else begin
      mem_read_s = 1'b0;
    end
  end

  // State and registered-output update; reset overrides everything, including an active transfer.
  always_ff @(posedge sck) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      phase_data_r <= 1'b0;
      base_r       <= {ADDR_SIZE{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      bit_r        <= 3'd0;
      div_r        <= {DIV_W{1'b0}};
      shreg_r      <= 8'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_addr_r   <= {ADDR_SIZE{1'b0}};
      sce_r        <= 1'b1;
      dc_r         <= 1'b0;
      sdin_r       <= 1'b0;
      sclk_r       <= 1'b0;
`ifndef SCN_CFG_EVERY_FRAME_EN
      cfg_sent_r   <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      phase_data_r <= phase_data_s;
      base_r       <= base_s;
      idx_r        <= idx_s;
      bit_r        <= bit_s;
      div_r        <= div_s;
      shreg_r      <= shreg_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      mem_read_r   <= mem_read_s;
      mem_addr_r   <= mem_addr_s;
      sce_r        <= sce_s;
      dc_r         <= dc_s;
      sdin_r       <= sdin_s;
      sclk_r       <= sclk_s;
`ifndef SCN_CFG_EVERY_FRAME_EN
      cfg_sent_r   <= cfg_sent_s;
`endif
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign mem_read = mem_read_r;
  assign mem_addr = mem_addr_r;
  assign lcd_sce  = sce_r;
  assign lcd_dc   = dc_r;
  assign lcd_sdin = sdin_r;
  assign lcd_sclk = sclk_r;

endmodule

// File: tb/tb_scn_spi_streamer.sv
// Self-checking bench for scn_spi_streamer: cycle vectors for the start of a frame, then whole frames checked against a byte-level model.
module tb_scn_spi_streamer;

  localparam int CLK_DIV_TB = 2;
  localparam int BYTE_CYC   = 2 + 16 * CLK_DIV_TB;

  logic        sck;
  logic        reset;
  logic        start;
  logic [3:0]  scn_sel;
  logic        busy, done, mem_read;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        lcd_sce, lcd_dc, lcd_sdin, lcd_sclk;

  scn_spi_streamer #(.CLK_DIV(CLK_DIV_TB)) dut (
    .sck(sck), .reset(reset), .start(start), .scn_sel(scn_sel),
    .busy(busy), .done(done), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_data(mem_data), .lcd_sce(lcd_sce), .lcd_dc(lcd_dc),
    .lcd_sdin(lcd_sdin), .lcd_sclk(lcd_sclk)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  logic [7:0]  ram [0:8191];
  logic [7:0]  rd_data;
  assign mem_data = rd_data;

  logic [12:0] addr_q[$];
  logic [8:0]  cap_q[$];
  int          done_cnt;
  int          sce_rise;
  int          mon_nb;
  logic [7:0]  mon_sh;
  logic        prev_sclk, prev_sce;

  int          n_checks;
  int          n_fail;
  bit          model_cfg_sent;

  // Negedge-registered RAM plus SPI/bus monitor: logs fetch addresses and reassembles bytes at lcd_sclk rises.
  initial begin
    rd_data = 8'd0; done_cnt = 0; sce_rise = 0; mon_nb = 0; mon_sh = 8'd0;
    prev_sclk = 1'b0; prev_sce = 1'b1;
  end
  always @(negedge sck) begin
    if (mem_read) rd_data = ram[mem_addr];
    if (reset) begin
      mon_nb = 0; prev_sclk = 1'b0; prev_sce = 1'b1;
    end else begin
      if (mem_read) addr_q.push_back(mem_addr);
      if (done) done_cnt++;
      if (lcd_sce && !prev_sce) sce_rise++;
      if (lcd_sclk && !prev_sclk && !lcd_sce) begin
        mon_sh = {mon_sh[6:0], lcd_sdin};
        mon_nb++;
        if (mon_nb == 8) begin
          cap_q.push_back({lcd_dc, mon_sh});
          mon_nb = 0;
        end
      end
      prev_sclk = lcd_sclk;
      prev_sce  = lcd_sce;
    end
  end

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // One frame from start to done (or to a mid-frame reset), checked against the byte list the rules predict.
  task automatic run_frame(input logic [3:0] sel, input bit pulse_mid, input bit start_on_done, input bit abort);
    logic [12:0] exp_addr[$];
    logic [8:0]  exp_cap[$];
    logic [12:0] base, a;
    bit          with_cfg;
    int          a0, c0, d0, r0, n, nbytes, n_exp, limit, p1, p2, mism, na, nc;
`ifdef SCN_CFG_EVERY_FRAME_EN
    with_cfg = 1'b1;
`else
    with_cfg = !model_cfg_sent;
`endif
    base = 13'(32'd5 + 32'(sel) * 32'd504);
    if (with_cfg) begin
      for (int i = 0; i < 5; i++) begin
        exp_addr.push_back(13'(i));
        exp_cap.push_back({1'b0, ram[i]});
      end
    end
    for (int i = 0; i < 504; i++) begin
      a = base + 13'(i);
      exp_addr.push_back(a);
      exp_cap.push_back({1'b1, ram[a]});
    end
    nbytes = exp_addr.size();
    n_exp  = 1 + nbytes * BYTE_CYC;
    limit  = n_exp + 100;
    p1 = $urandom_range(2, n_exp - 10);
    p2 = $urandom_range(2, n_exp - 10);
    a0 = addr_q.size(); c0 = cap_q.size(); d0 = done_cnt; r0 = sce_rise;

    scn_sel = sel;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    scn_sel = ~sel;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    n = 1;
    while (!done && n < limit) begin
      if (abort && (cap_q.size() - c0) == 100 && mon_nb == 4) break;
      start = pulse_mid && (n == p1 || n == p2);
      tick();
      n++;
    end
    start = 1'b0;
    na = addr_q.size() - a0;
    nc = cap_q.size() - c0;

    if (abort) begin
      check("abort_point_reached", nc, 32'd100);
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check("midframe_reset_outputs", {27'd0, lcd_sce, lcd_sclk, busy, mem_read, done}, 32'b10000);
      tick();
      check("start_with_reset_ignored", {30'd0, busy, mem_read}, 32'd0);
      model_cfg_sent = 1'b0;
      mism = 0;
      if (nc >= 100 && na >= 100) begin
        for (int i = 0; i < 100; i++) begin
          if (cap_q[c0 + i] !== exp_cap[i]) mism++;
          if (addr_q[a0 + i] !== exp_addr[i]) mism++;
        end
      end else begin
        mism = 1000;
      end
      check("abort_prefix_mismatches", mism, 32'd0);
    end else begin
      check("done_cycle", n, n_exp);
      check("first_fetch_addr", (na > 0) ? {19'd0, addr_q[a0]} : 32'hFFFF_FFFF, {19'd0, exp_addr[0]});
      check("fetch_count", na, nbytes);
      check("spi_byte_count", nc, nbytes);
      mism = 0;
      for (int i = 0; i < nbytes; i++) begin
        if (i < na && addr_q[a0 + i] !== exp_addr[i]) mism++;
        if (i < nc && cap_q[c0 + i] !== exp_cap[i]) mism++;
      end
      check("frame_content_mismatches", mism, 32'd0);
      if (with_cfg) model_cfg_sent = 1'b1;
      if (start_on_done) begin
        scn_sel = sel ^ 4'd5;
        start   = 1'b1;
      end else begin
        start   = 1'b0;
      end
      tick();
      check("busy_low_after_fin", {31'd0, busy}, 32'd0);
      check("no_fetch_after_fin", {31'd0, mem_read}, 32'd0);
      check("done_pulses", done_cnt - d0, 32'd1);
      check("sce_single_rise", sce_rise - r0, 32'd1);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       st;
    logic [3:0] sel;
    logic [6:0] exp;     // {busy, mem_read, lcd_sce, lcd_dc, lcd_sclk, done, lcd_sdin}
    logic [12:0] addr;   // checked only while mem_read is expected
  } vec_t;

  vec_t tv[11];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_cfg_sent = 1'b0;
    reset   = 1'b1;
    start   = 1'b0;
    scn_sel = 4'd0;
    for (int i = 0; i < 8192; i++) ram[i] = 8'(i ^ (i >> 8));

    tv[0]  = '{1'b1, 1'b0, 4'd0, 7'b0010000, 13'd0};
    tv[1]  = '{1'b0, 1'b0, 4'd0, 7'b0010000, 13'd0};
    tv[2]  = '{1'b0, 1'b1, 4'd3, 7'b1110000, 13'd0};
    tv[3]  = '{1'b0, 1'b1, 4'd3, 7'b1010000, 13'd0};
    tv[4]  = '{1'b0, 1'b0, 4'd0, 7'b1000000, 13'd0};
    tv[5]  = '{1'b0, 1'b0, 4'd0, 7'b1000000, 13'd0};
    tv[6]  = '{1'b0, 1'b0, 4'd0, 7'b1000100, 13'd0};
    tv[7]  = '{1'b0, 1'b0, 4'd0, 7'b1000100, 13'd0};
    tv[8]  = '{1'b0, 1'b0, 4'd0, 7'b1000000, 13'd0};
    tv[9]  = '{1'b1, 1'b1, 4'd0, 7'b0010000, 13'd0};
    tv[10] = '{1'b0, 1'b0, 4'd0, 7'b0010000, 13'd0};

    for (int i = 0; i < 11; i++) begin
      reset   = tv[i].rst;
      start   = tv[i].st;
      scn_sel = tv[i].sel;
      tick();
      check($sformatf("vec%0d_outputs", i),
            {25'd0, busy, mem_read, lcd_sce, lcd_dc, lcd_sclk, done, lcd_sdin}, {25'd0, tv[i].exp});
      if (tv[i].exp[5]) check($sformatf("vec%0d_addr", i), {19'd0, mem_addr}, {19'd0, tv[i].addr});
    end
    reset = 1'b0;
    start = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outputs", {28'd0, lcd_sce, lcd_sclk, busy, mem_read}, 32'b1000);
    end

    run_frame(4'd0, 1'b0, 1'b0, 1'b0);
    run_frame(4'd15, 1'b0, 1'b0, 1'b0);
    run_frame(4'($urandom_range(0, 15)), 1'b1, 1'b1, 1'b0);
    run_frame(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);
    run_frame(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
